switch_button_input_interface: RTL and testbench
================================================

Name: switch_button_input_interface

Overview:
- Input-side counterpart to the board's 7-segment block-select display.
- Synchronizes and debounces the write-block switch, the read-block switch and a commit push-button.
- Presents clean block-select levels to the display and datapath.
- Issues a valid/ready commit command to the memory controller on each debounced button press.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz); minimum 2.
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer; minimum 2.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- switch0  in  1  raw write-block switch (0 = block 1, 1 = block 2).
- switch1  in  1  raw read-block switch (0 = block 1, 1 = block 2).
- button  in  1  raw commit push-button, active-high.
- wr_blk_sel  out  1  debounced switch0 level.
- rd_blk_sel  out  1  debounced switch1 level.
- sel_changed  out  1  one-cycle pulse when wr_blk_sel or rd_blk_sel changes.
- cmd_valid  out  1  commit command pending.
- cmd_ready  in  1  controller accepts command.
- cmd_wr_blk  out  1  write block captured with the command.
- cmd_rd_blk  out  1  read block captured with the command.
- cmd_dropped  out  1  one-cycle pulse when a press is lost because a command is still pending.

Behaviour:
- Reset: reset_n low at a clock edge clears every register to 0 (sync chains, debounce counters, stable levels, FSM = IDLE, all outputs 0). It has identical effect mid-debounce or mid-handshake, and a pending command is discarded.
- Synchronizer: each raw input passes through a SYNC_STAGES flop chain. The last stage is the sampled value s.
- Debouncer, per input:
  - Holds a stable level q and a counter cnt, width $clog2(DEBOUNCE_CYCLES).
  - If s == q: cnt <= 0.
  - If s != q and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - If s != q and cnt == DEBOUNCE_CYCLES-1: q <= s and cnt <= 0.
  - Any glitch back to q before terminal count restarts the count.
  - Latency from a clean raw edge to a q change is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- wr_blk_sel and rd_blk_sel are registered q outputs.
- sel_changed is high in the cycle after either q changes. If both change together, it gives one pulse.
- Press detect: rise = btn_q & ~btn_q_d, a one-cycle pulse. Button release produces no event.
- Command FSM, states IDLE and PENDING:
  - IDLE, rise: cmd_wr_blk <= wr_blk_sel, cmd_rd_blk <= rd_blk_sel, cmd_valid <= 1, go to PENDING.
  - PENDING, cmd_ready and no rise: cmd_valid <= 0, go to IDLE.
  - PENDING, cmd_ready and rise in the same cycle: the old command transfers, the new one is captured, cmd_valid stays 1, FSM stays in PENDING.
  - PENDING, rise without cmd_ready: the press is ignored, cmd_dropped pulses for 1 cycle, and the captured fields are unchanged.
  - cmd_wr_blk and cmd_rd_blk are held constant while cmd_valid is 1.
  - cmd_valid never drops without cmd_ready.
  - cmd_ready in IDLE is ignored.
- Capture uses the debounced select values present in the cycle of rise. This includes a select that changes in that same cycle, which captures its pre-change value.

Optional Feature:
- Macro: SWITCH_CMD_EN.
- Defined: a debounced change of either select is treated exactly like a button rise. It has the same capture, drop and same-cycle-accept rules and captures the new select values. A button rise and a switch change in the same cycle produce a single command.
- Undefined: only button rise issues commands. Switch changes affect wr_blk_sel, rd_blk_sel and sel_changed only.

Decomposition:
- Package seg_io_pkg:
  - cmd_state_e enum {IDLE, PENDING}.
  - blk_cmd_t packed struct {wr_blk, rd_blk}.
  - localparams BLK1 = 1'b0, BLK2 = 1'b1.
- Sub-module input_debouncer (params DEBOUNCE_CYCLES, SYNC_STAGES): sync chain plus counter. Instantiated 3 times.
- Top level holds edge detect, change detect and the command FSM.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: hold reset_n=0 for 3 cycles with all inputs 1 → every output is 0. After release, wr_blk_sel=1 exactly 6 cycles later.
- Bounce: toggle switch0 0/1 every 2 cycles for 20 cycles, then hold 1 → wr_blk_sel changes only once, 6 cycles after the final edge. sel_changed pulses exactly once.
- Handshake: switch0=1, switch1=0, press button with cmd_ready=0 → cmd_valid=1, cmd_wr_blk=1, cmd_rd_blk=0, held 10 cycles. Then cmd_ready=1 for 1 cycle → cmd_valid=0 next cycle.
- Drop: second press while PENDING with cmd_ready=0 → cmd_dropped pulses once and the fields are unchanged.
- Same-cycle accept: align cmd_ready=1 with a new rise in PENDING → cmd_valid stays 1 and the fields update to the new selects.
- Mid-operation reset: assert reset_n=0 while PENDING and a debounce count is at 2 → next cycle cmd_valid=0 and the counter restarts from 0. With SWITCH_CMD_EN, flipping switch1 alone issues a command with cmd_rd_blk=1.

Source files
------------

// File: rtl/seg_io_pkg.sv
// Shared types for the switch/button input interface and its command handshake.
// Used by switch_button_input_interface (optional build macro: SWITCH_CMD_EN).
package seg_io_pkg;

  localparam logic BLK1 = 1'b0;
  localparam logic BLK2 = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cmd_state_e;

  typedef struct packed {
    logic wr_blk;
    logic rd_blk;
  } blk_cmd_t;

endpackage

// File: rtl/input_debouncer.sv
// Synchronizer chain followed by a stable-level debouncer for one raw board input.
// The level follows the input only after DEBOUNCE_CYCLES consecutive differing samples.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_q
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];
  assign o_q = r_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_q    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      // any sample equal to the held level restarts the qualification window
      if (w_s == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == TC) begin
        r_q   <= w_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/switch_button_input_interface.sv
// Debounced block-select switches and commit button feeding a valid/ready command port.
// Build macro SWITCH_CMD_EN: a debounced select change also issues a command.
//   state   | meaning
//   IDLE    | no command outstanding, cmd_valid low
//   PENDING | captured command held on cmd_* until cmd_ready
module switch_button_input_interface
  import seg_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic switch0,
  input  logic switch1,
  input  logic button,
  output logic wr_blk_sel,
  output logic rd_blk_sel,
  output logic sel_changed,
  output logic cmd_valid,
  input  logic cmd_ready,
  output logic cmd_wr_blk,
  output logic cmd_rd_blk,
  output logic cmd_dropped
);

  logic       w_wr_q;
  logic       w_rd_q;
  logic       w_btn_q;
  logic       w_rise;
  logic       w_sel_change;
  logic       w_event;
  logic       r_wr_d;
  logic       r_rd_d;
  logic       r_btn_d;
  logic       r_dropped;
  cmd_state_e r_state;
  blk_cmd_t   r_cmd;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_wr (
    .clock(clock), .reset_n(reset_n), .i_raw(switch0), .o_q(w_wr_q)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_rd (
    .clock(clock), .reset_n(reset_n), .i_raw(switch1), .o_q(w_rd_q)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_btn (
    .clock(clock), .reset_n(reset_n), .i_raw(button), .o_q(w_btn_q)
  );

  assign w_rise       = w_btn_q & ~r_btn_d;
  assign w_sel_change = (w_wr_q ^ r_wr_d) | (w_rd_q ^ r_rd_d);

`ifdef SWITCH_CMD_EN
  assign w_event = w_rise | w_sel_change;
`else
  assign w_event = w_rise;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wr_d    <= 1'b0;
      r_rd_d    <= 1'b0;
      r_btn_d   <= 1'b0;
      r_dropped <= 1'b0;
      r_state   <= IDLE;
      r_cmd     <= '{wr_blk: BLK1, rd_blk: BLK1};
    end else begin
      r_wr_d    <= w_wr_q;
      r_rd_d    <= w_rd_q;
      r_btn_d   <= w_btn_q;
      r_dropped <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_event) begin
            r_cmd   <= '{wr_blk: w_wr_q, rd_blk: w_rd_q};
            r_state <= PENDING;
          end
        end
        PENDING: begin
          // accept and re-capture in one cycle keeps cmd_valid high
          if (cmd_ready) begin
            if (w_event) begin
              r_cmd <= '{wr_blk: w_wr_q, rd_blk: w_rd_q};
            end else begin
              r_state <= IDLE;
            end
          end else if (w_event) begin
            r_dropped <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_blk_sel  = w_wr_q;
  assign rd_blk_sel  = w_rd_q;
  assign sel_changed = w_sel_change;
  assign cmd_valid   = (r_state == PENDING);
  assign cmd_wr_blk  = r_cmd.wr_blk;
  assign cmd_rd_blk  = r_cmd.rd_blk;
  assign cmd_dropped = r_dropped;

endmodule

// File: tb/tb_switch_button_input_interface.sv
// Self-checking bench for switch_button_input_interface with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Commands are scoreboarded: expected fields queued at stimulus, popped on each handshake.
module tb_switch_button_input_interface;
  import seg_io_pkg::*;

  logic clock = 1'b0;
  logic reset_n, switch0, switch1, button, cmd_ready;
  logic wr_blk_sel, rd_blk_sel, sel_changed, cmd_valid, cmd_wr_blk, cmd_rd_blk, cmd_dropped;

  int n_checks = 0;
  int n_fail   = 0;
  blk_cmd_t exp_q[$];

  switch_button_input_interface #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .switch0(switch0), .switch1(switch1), .button(button),
    .wr_blk_sel(wr_blk_sel), .rd_blk_sel(rd_blk_sel), .sel_changed(sel_changed),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_blk(cmd_wr_blk),
    .cmd_rd_blk(cmd_rd_blk), .cmd_dropped(cmd_dropped)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_cmd(input logic wr, input logic rd);
    blk_cmd_t e;
    e.wr_blk = wr;
    e.rd_blk = rd;
    exp_q.push_back(e);
  endtask

  // handshake monitor: every accepted command must match the oldest expected one
  always @(negedge clock) begin
    if (reset_n === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_cmd", 1, 0);
      end else begin
        blk_cmd_t e;
        e = exp_q.pop_front();
        check_eq("sb_wr_blk", cmd_wr_blk, e.wr_blk);
        check_eq("sb_rd_blk", cmd_rd_blk, e.rd_blk);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int chg, pulses, held, drops, exp_drops;
    logic prev;

    // reset with every input high
    reset_n = 1'b0; switch0 = 1'b1; switch1 = 1'b1; button = 1'b1; cmd_ready = 1'b1;
    tick(3);
    check_eq("rst_wr_blk_sel", wr_blk_sel, 0);
    check_eq("rst_rd_blk_sel", rd_blk_sel, 0);
    check_eq("rst_sel_changed", sel_changed, 0);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_cmd_fields", {cmd_wr_blk, cmd_rd_blk}, 0);
    check_eq("rst_cmd_dropped", cmd_dropped, 0);
    reset_n = 1'b1;
    push_cmd(1'b1, 1'b1);
    tick(5);
    check_eq("rel_lat5_wr", wr_blk_sel, 0);
    tick(1);
    check_eq("rel_lat6_wr", wr_blk_sel, 1);
    check_eq("rel_lat6_rd", rd_blk_sel, 1);
    check_eq("rel_sel_changed", sel_changed, 1);
    tick(1);
    check_eq("rel_cmd_valid", cmd_valid, 1);
    tick(1);
    check_eq("rel_cmd_done", cmd_valid, 0);

    // both selects to block 1, button released
    button = 1'b0; switch0 = 1'b0; switch1 = 1'b0;
`ifdef SWITCH_CMD_EN
    push_cmd(1'b0, 1'b0);
`endif
    tick(12);
    check_eq("sel_low_wr", wr_blk_sel, 0);
    check_eq("sel_low_rd", rd_blk_sel, 0);

    // bounce on switch0, then settle high
    chg = 0; pulses = 0; prev = wr_blk_sel;
    for (int i = 0; i < 10; i++) begin
      switch0 = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        tick(1);
        if (wr_blk_sel !== prev) chg++;
        prev = wr_blk_sel;
        if (sel_changed === 1'b1) pulses++;
      end
    end
    switch0 = 1'b1;
`ifdef SWITCH_CMD_EN
    push_cmd(1'b1, 1'b0);
`endif
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (wr_blk_sel !== prev) chg++;
      prev = wr_blk_sel;
      if (sel_changed === 1'b1) pulses++;
      if (k == 5) check_eq("bounce_lat5_wr", wr_blk_sel, 0);
      if (k == 6) check_eq("bounce_lat6_wr", wr_blk_sel, 1);
    end
    check_eq("bounce_changes", chg, 1);
    check_eq("bounce_sel_pulses", pulses, 1);

    // handshake with controller stalled
    cmd_ready = 1'b0;
    button = 1'b1;
    push_cmd(1'b1, 1'b0);
    tick(6);
    check_eq("hs_not_yet_valid", cmd_valid, 0);
    tick(1);
    check_eq("hs_valid", cmd_valid, 1);
    check_eq("hs_fields", {cmd_wr_blk, cmd_rd_blk}, 2'b10);
    button = 1'b0;
    held = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (cmd_valid === 1'b1 && cmd_wr_blk === 1'b1 && cmd_rd_blk === 1'b0) held++;
    end
    check_eq("hs_held_cycles", held, 10);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check_eq("hs_released", cmd_valid, 0);

    // drop: second press (and, with switch commands, a select change) while pending
    button = 1'b1;
    push_cmd(1'b1, 1'b0);
    tick(7);
    check_eq("drop_first_valid", cmd_valid, 1);
    button = 1'b0; switch1 = 1'b1;
    drops = 0; held = 0;
    for (int k = 0; k < 18; k++) begin
      if (k == 8) button = 1'b1;
      tick(1);
      if (cmd_dropped === 1'b1) drops++;
      if (cmd_valid === 1'b1 && cmd_wr_blk === 1'b1 && cmd_rd_blk === 1'b0) held++;
    end
`ifdef SWITCH_CMD_EN
    exp_drops = 2;
`else
    exp_drops = 1;
`endif
    check_eq("drop_pulses", drops, exp_drops);
    check_eq("drop_fields_held", held, 18);

    // same-cycle accept and new press
    button = 1'b0;
    tick(8);
    button = 1'b1;
    push_cmd(1'b1, 1'b1);
    tick(6);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check_eq("sca_valid_stays", cmd_valid, 1);
    check_eq("sca_new_fields", {cmd_wr_blk, cmd_rd_blk}, 2'b11);
    check_eq("sca_no_drop", cmd_dropped, 0);

    // reset while pending and mid-debounce on switch0
    button = 1'b0; switch0 = 1'b0;
    tick(4);
    reset_n = 1'b0;
    exp_q.delete();
    tick(1);
    check_eq("mrst_cmd_valid", cmd_valid, 0);
    check_eq("mrst_cmd_fields", {cmd_wr_blk, cmd_rd_blk}, 0);
    check_eq("mrst_sel", {wr_blk_sel, rd_blk_sel}, 0);
    reset_n = 1'b1;
    tick(5);
    check_eq("mrst_lat5_rd", rd_blk_sel, 0);
    tick(1);
    check_eq("mrst_lat6_rd", rd_blk_sel, 1);
    check_eq("mrst_wr_stays", wr_blk_sel, 0);
`ifdef SWITCH_CMD_EN
    push_cmd(1'b0, 1'b1);
    tick(1);
    check_eq("swcmd_valid", cmd_valid, 1);
    check_eq("swcmd_fields", {cmd_wr_blk, cmd_rd_blk}, 2'b01);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check_eq("swcmd_done", cmd_valid, 0);
`else
    tick(1);
    check_eq("no_swcmd_valid", cmd_valid, 0);
`endif
    tick(2);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
